// File: rtl/fifo_cdc_pkg.sv
// Shared definitions for the asynchronous CDC FIFO (read side fifo_rptr_empty
// and write side fifo_wptr_full).
//
// Contents:
//   ADDRSIZE       default RAM address width (depth = 2**ADDRSIZE)
//   AEMPTY_THRESH  default almost-empty threshold, in entries
//   MAX_PTR_W      widest pointer the helper functions handle
//   bin2gray       binary -> reflected Gray code
//   gray2bin       reflected Gray code -> binary
//
// The helpers work on MAX_PTR_W-bit values. A pointer of width addrsize+1 is
// zero-extended on the way in and truncated on the way out. Both conversions
// are exact under zero-extension, because leading zeros map to leading zeros in
// either direction.
package fifo_cdc_pkg;

  localparam int ADDRSIZE      = 8;
  localparam int AEMPTY_THRESH = 2;
  localparam int MAX_PTR_W     = 32;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
//
// Binary bit i is the XOR of all Gray bits from i up to the MSB, which is a
// prefix XOR taken from the top down.
//
// Parameters:
//   W     word width
// Ports:
//   gray  input  [W-1:0]  Gray-coded value
//   bin   output [W-1:0]  equivalent binary value
module gray_to_bin #(
  parameter int W = 9
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and empty-flag stage of the asynchronous CDC FIFO.
//
// The block keeps a binary read pointer rbin, which drives the RAM address, and
// a registered Gray copy rptr, which goes back to the write domain. It compares
// the next Gray pointer with the synchronized write pointer to produce a
// registered empty flag. From the same comparison point it also derives the
// fill level, which gives the almost-empty flag.
//
// Handshake: rd_en is a read request. A read is accepted on a clk edge where
// rd_en=1 and rempty=0. Only an accepted read advances the pointer. A request
// made while rempty=1 is dropped and sets the sticky rd_underflow flag.
//
// Parameters:
//   addrsize       RAM address width; pointers are addrsize+1 bits
//   AEMPTY_THRESH  ralmost_empty is set while level <= AEMPTY_THRESH
// Ports:
//   clk            read-domain clock
//   rst            asynchronous active-high reset
//   rd_en          read request
//   rq2_wptr       Gray write pointer, already synchronized to clk
//   clr_underflow  clears rd_underflow (a set in the same cycle wins)
//   raddr          RAM read address (rbin without its lap bit)
//   rptr           registered Gray read pointer
//   rempty         registered empty flag
//   ralmost_empty  registered almost-empty flag
//   rd_underflow   sticky flag, set by a read attempted while empty
//   rd_level       registered fill level (only with FIFO_RPTR_LEVEL_EN)
//
// Build option: define FIFO_RPTR_LEVEL_EN to add the rd_level output.
module fifo_rptr_empty #(
  parameter int addrsize      = fifo_cdc_pkg::ADDRSIZE,
  parameter int AEMPTY_THRESH = fifo_cdc_pkg::AEMPTY_THRESH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [addrsize:0]   rq2_wptr,
  input  logic                clr_underflow,
  output logic [addrsize-1:0] raddr,
  output logic [addrsize:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
`ifdef FIFO_RPTR_LEVEL_EN
  output logic                rd_underflow,
  output logic [addrsize:0]   rd_level
`else
  output logic                rd_underflow
`endif
);

  import fifo_cdc_pkg::*;

  localparam int PTR_W = addrsize + 1;
  localparam logic [PTR_W-1:0] AEMPTY_LIM = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbinnext;
  logic [PTR_W-1:0] rgraynext;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] level;
  logic             rinc;

  gray_to_bin #(.W(PTR_W)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  always_comb begin
    rinc      = rd_en & ~rempty;
    rbinnext  = rbin + PTR_W'(rinc);
    rgraynext = PTR_W'(bin2gray(MAX_PTR_W'(rbinnext)));
    // Modular subtraction at pointer width. Because the lap bit is included,
    // a full FIFO reads as 2**addrsize rather than 0.
    level     = wbin - rbinnext;
  end

  assign raddr = rbin[addrsize-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rd_underflow  <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      // Full-width Gray equality: identical pointers on the same lap.
      rempty        <= (rgraynext == rq2_wptr);
      ralmost_empty <= (level <= AEMPTY_LIM);
      if (rd_en && rempty) begin
        rd_underflow <= 1'b1;
      end else if (clr_underflow) begin
        rd_underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_RPTR_LEVEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_level <= '0;
    end else begin
      rd_level <= level;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for fifo_rptr_empty with addrsize=4 (depth 16, pointer mod 32) and
// AEMPTY_THRESH=2. The reference model tracks the read and write positions as
// plain integers and derives empty, level, almost-empty and underflow with
// modular arithmetic.
module tb_fifo_rptr_empty;

  localparam int AW  = 4;
  localparam int PW  = AW + 1;
  localparam int MOD = 32;
  localparam int DEP = 16;
  localparam int THR = 2;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic          clr_underflow;
  logic [PW-1:0] rq2_wptr;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic          rd_underflow;
`ifdef FIFO_RPTR_LEVEL_EN
  logic [PW-1:0] rd_level;
`endif

  always #5 clk = ~clk;

  fifo_rptr_empty #(.addrsize(AW), .AEMPTY_THRESH(THR)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .rq2_wptr      (rq2_wptr),
    .clr_underflow (clr_underflow),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
`ifdef FIFO_RPTR_LEVEL_EN
    .rd_underflow  (rd_underflow),
    .rd_level      (rd_level)
`else
    .rd_underflow  (rd_underflow)
`endif
  );

  // reference model state
  int m_rbin, m_wbin, m_level;
  bit m_empty, m_aempty, m_uf;

  // scoreboard
  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".raddr"},  32'(raddr),         32'(m_rbin % DEP));
    check({tag, ".rptr"},   32'(rptr),          32'(gray(m_rbin)));
    check({tag, ".rempty"}, 32'(rempty),        32'(m_empty));
    check({tag, ".raempty"},32'(ralmost_empty), 32'(m_aempty));
    check({tag, ".uflow"},  32'(rd_underflow),  32'(m_uf));
`ifdef FIFO_RPTR_LEVEL_EN
    check({tag, ".level"},  32'(rd_level),      32'(m_level));
`endif
  endtask

  // driver: one clock cycle with the given request, clear and write position
  task automatic step(input bit rd, input bit clr, input int wbin_new, input string tag);
    bit acc, uf_set;
    rd_en         = rd;
    clr_underflow = clr;
    rq2_wptr      = gray(wbin_new);
    acc    = rd && !m_empty;
    uf_set = rd && m_empty;
    if (acc) begin
      exp_q.push_back(AW'(m_rbin % DEP));
      check({tag, ".rd_addr"}, 32'(raddr), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    m_rbin   = (m_rbin + int'(acc)) % MOD;
    m_wbin   = wbin_new % MOD;
    m_level  = (m_wbin - m_rbin + MOD) % MOD;
    m_empty  = (m_level == 0);
    m_aempty = (m_level <= THR);
    m_uf     = uf_set ? 1'b1 : (clr ? 1'b0 : m_uf);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rd_en         = 1'b0;
    clr_underflow = 1'b0;
    rq2_wptr      = '0;
    rst           = 1'b1;
    #1;
    m_rbin = 0; m_wbin = 0; m_level = 0;
    m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
    check({tag, ".raddr"},  32'(raddr), 0);
    check({tag, ".rptr"},   32'(rptr), 0);
    check({tag, ".rempty"}, 32'(rempty), 1);
    check({tag, ".raempty"},32'(ralmost_empty), 1);
    check({tag, ".uflow"},  32'(rd_underflow), 0);
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; clr_underflow = 1'b0; rq2_wptr = '0;
    #2;
    do_reset("por");
    step(0, 0, 0, "idle");

    // drain three entries, then one read while empty
    step(0, 0, 3, "drain_w");
    check("drain_rempty_fall", 32'(rempty), 0);
    for (int k = 0; k < 4; k++) begin
      check("drain_raddr", 32'(raddr), 32'(k < 3 ? k : 3));
      step(1, 0, 3, "drain");
      if (k == 2) check("drain_rempty_rise", 32'(rempty), 1);
    end
    check("drain_uflow", 32'(rd_underflow), 1);
    check("drain_raddr_hold", 32'(raddr), 3);

    // bring rbin to 5, then reset asynchronously mid-stream
    step(0, 0, 4, "mid_w");
    step(1, 0, 5, "mid_r");
    step(1, 0, 5, "mid_r");
    check("mid_raddr", 32'(raddr), 5);
    do_reset("mid_rst");

    // wrap: stream writes and reads until rbin=30
    for (int i = 0; i < 200 && m_rbin != 30; i++) begin
      step(1, 0, (m_wbin + 1) % MOD, "pre_wrap");
    end
    check("wrap_preload", 32'(raddr), 14);
    step(1, 0, 0, "wrap");
    check("wrap_rptr31", 32'(rptr), 32'(gray(31)));
    step(1, 0, 1, "wrap");
    check("wrap_rptr0", 32'(rptr), 32'(gray(0)));
    step(1, 0, 1, "wrap");
    check("wrap_rptr1", 32'(rptr), 32'(gray(1)));
    check("wrap_empty", 32'(rempty), 1);

    // almost-empty from a full lap
    do_reset("ae_rst");
    for (int w = 1; w <= 16; w++) step(0, 0, w, "ae_fill");
    check("ae_full_rempty", 32'(rempty), 0);
    check("ae_full_raempty", 32'(ralmost_empty), 0);
    for (int k = 1; k <= 14; k++) begin
      step(1, 0, 16, "ae_read");
      if (k == 13) check("ae_level3", 32'(ralmost_empty), 0);
      if (k == 14) check("ae_level2", 32'(ralmost_empty), 1);
    end

    // underflow: set wins over clear, then clear alone
    step(1, 0, 16, "uf_drain");
    step(1, 0, 16, "uf_drain");
    check("uf_empty", 32'(rempty), 1);
    step(1, 1, 16, "uf_prio");
    check("uf_set_wins", 32'(rd_underflow), 1);
    step(0, 1, 16, "uf_clr");
    check("uf_cleared", 32'(rd_underflow), 0);

`ifdef FIFO_RPTR_LEVEL_EN
    do_reset("lvl_rst");
    for (int w = 1; w <= 7; w++) step(0, 0, w, "lvl_fill");
    step(1, 0, 7, "lvl_r");
    step(1, 0, 7, "lvl_r");
    check("lvl_5", 32'(rd_level), 5);
    step(1, 0, 7, "lvl_r");
    check("lvl_4", 32'(rd_level), 4);
`endif

    // randomized traffic; the write side only advances while not full
    do_reset("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      int  nw;
      bit  rd, clr;
      rd  = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 7) == 0);
      nw  = m_wbin;
      if ((((m_wbin + 1 - m_rbin) + MOD) % MOD) <= DEP && $urandom_range(0, 1) == 1)
        nw = (m_wbin + 1) % MOD;
      step(rd, clr, nw, "rnd");
      if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
